// File: rtl/csa_stream_accumulator_pkg.sv
// Shared types and helpers for the carry-save stream accumulator.
// ACC_W/CNT_W/NCH describe the default build; the top derives its own from its parameters.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC     = 2'd1,
    RESOLVE = 2'd2,
    HOLD    = 2'd3
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  localparam int WIDTH_DEF   = 4;
  localparam int MAX_OPS_DEF = 16;
  localparam int CHUNK_DEF   = 4;
  localparam int ACC_W       = WIDTH_DEF + clog2(MAX_OPS_DEF);
  localparam int CNT_W       = clog2(MAX_OPS_DEF) + 1;
  localparam int NCH         = ACC_W / CHUNK_DEF;

endpackage

// File: rtl/csa_stream_accumulator_if.sv
// Operand stream in, resolved result out. master = source/consumer side, slave = accumulator.
interface csa_stream_accumulator_if #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8,
  parameter int CNT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );
endinterface

// File: rtl/csa_stream_accumulator_row.sv
// One carry-save row: N independent full adders producing a sum vector and an unshifted carry vector.
module fulladder
  import csa_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = maj3(a_i, b_i, ci_i);
endmodule

module csa_row #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] c_i,
  output logic [N-1:0] sum_o,
  output logic [N-1:0] carry_o
);
  for (genvar g = 0; g < N; g++) begin : g_fa
    fulladder u_fa (
      .a_i (a_i[g]),
      .b_i (b_i[g]),
      .ci_i(c_i[g]),
      .s_o (sum_o[g]),
      .co_o(carry_o[g])
    );
  end
endmodule

// File: rtl/csa_stream_accumulator.sv
// Packet accumulator: operands are folded into sum/carry registers one CSA row per beat,
// then S+C is resolved to binary CHUNK bits per cycle before being offered downstream.
module csa_stream_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_OPS = 16,
  parameter int CHUNK   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  csa_stream_accumulator_if.slave  bus
);

  localparam int SUM_W    = WIDTH + clog2(MAX_OPS);
  localparam int CNT_BITS = clog2(MAX_OPS) + 1;
  localparam int N_CHUNKS = SUM_W / CHUNK;
  localparam int IDX_W    = (N_CHUNKS > 1) ? clog2(N_CHUNKS) : 1;

  state_e              state_q, state_d;
  logic [SUM_W-1:0]    s_q, s_d, c_q, c_d;
  logic [SUM_W-1:0]    res_q, res_d, sum_q, sum_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d, count_q, count_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                cy_q, cy_d;

  logic [SUM_W-1:0]    din, row_s, row_c;
  logic [CNT_BITS-1:0] cnt_inc;
  logic [CHUNK:0]      slice;
  logic                in_ready, accept, eop;

  assign din = {{(SUM_W-WIDTH){1'b0}}, bus.in_data};

  csa_row #(.N(SUM_W)) u_row (
    .a_i    (s_q),
    .b_i    (c_q),
    .c_i    (din),
    .sum_o  (row_s),
    .carry_o(row_c)
  );

  assign in_ready = (state_q == IDLE) || (state_q == ACC);
  assign accept   = bus.in_valid && in_ready;
  assign cnt_inc  = cnt_q + CNT_BITS'(1);
  assign eop      = bus.in_last || (cnt_inc == CNT_BITS'(MAX_OPS));

  // The chunk carry-out feeds the next slice through cy_q, so one adder of CHUNK bits suffices.
  assign slice = {1'b0, s_q[idx_q*CHUNK +: CHUNK]}
               + {1'b0, c_q[idx_q*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, cy_q};

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    unique case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          s_d   = row_s;
          c_d   = row_c << 1;
          cnt_d = cnt_inc;
          if (eop) begin
            state_d = RESOLVE;
            idx_d   = '0;
            cy_d    = 1'b0;
          end else begin
            state_d = ACC;
          end
        end
      end
      RESOLVE: begin
        res_d[idx_q*CHUNK +: CHUNK] = slice[CHUNK-1:0];
        cy_d  = slice[CHUNK];
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N_CHUNKS-1)) begin
          sum_d   = res_d;
          count_d = cnt_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      count_q <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = sum_q;
  assign bus.out_count = count_q;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed bench for csa_stream_accumulator: inputs driven and outputs sampled on the falling edge.
module tb_csa_stream_accumulator;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   n;

  csa_stream_accumulator_if #(.WIDTH(4), .ACC_W(8), .CNT_W(5)) bus ();

  csa_stream_accumulator #(.WIDTH(4), .MAX_OPS(16), .CHUNK(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output int cyc);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // 1: reset state
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_sum",   32'(bus.out_sum),   0);
    chk("rst_out_count", 32'(bus.out_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    // 2: 3+5+7, out_valid two edges after the last beat
    send(4'd3, 1'b0);
    send(4'd5, 1'b0);
    send(4'd7, 1'b1);
    chk("t2_valid_e0",  32'(bus.out_valid), 0);
    chk("t2_ready_e0",  32'(bus.in_ready),  0);
    @(negedge clk);
    chk("t2_valid_e1",  32'(bus.out_valid), 0);
    @(negedge clk);
    chk("t2_valid_e2",  32'(bus.out_valid), 1);
    chk("t2_sum",       32'(bus.out_sum),   15);
    chk("t2_count",     32'(bus.out_count), 3);
    take();
    chk("t2_valid_drop", 32'(bus.out_valid), 0);
    chk("t2_ready_back", 32'(bus.in_ready),  1);

    // 3: sixteen beats of 15, auto-terminate
    for (int i = 0; i < 16; i++) send(4'd15, 1'b0);
    chk("t3_ready_full", 32'(bus.in_ready), 0);
    wait_valid(10, n);
    chk("t3_latency", 32'(n), 2);
    chk("t3_sum",     32'(bus.out_sum),   240);
    chk("t3_count",   32'(bus.out_count), 16);
    take();

    // 4: single-beat packet
    send(4'd9, 1'b1);
    wait_valid(10, n);
    chk("t4_valid", 32'(bus.out_valid), 1);
    chk("t4_sum",   32'(bus.out_sum),   9);
    chk("t4_count", 32'(bus.out_count), 1);
    take();

    // 5: back-pressure with in_valid held high through RESOLVE/HOLD
    send(4'd1, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd2;
    bus.in_last  = 1'b1;
    @(negedge clk);
    bus.in_data  = 4'd8;
    wait_valid(10, n);
    chk("t5_valid", 32'(bus.out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      chk("t5_sum_hold",   32'(bus.out_sum),   3);
      chk("t5_ready_hold", 32'(bus.in_ready),  0);
      chk("t5_valid_hold", 32'(bus.out_valid), 1);
      @(negedge clk);
    end
    chk("t5_count", 32'(bus.out_count), 2);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    take();
    send(4'd4, 1'b1);
    wait_valid(10, n);
    chk("t5_next_sum",   32'(bus.out_sum),   4);
    chk("t5_next_count", 32'(bus.out_count), 1);
    take();

    // 6: reset mid-RESOLVE aborts the packet
    send(4'd15, 1'b0);
    send(4'd15, 1'b0);
    send(4'd15, 1'b1);
    @(negedge clk);
    chk("t6_valid_pre", 32'(bus.out_valid), 0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.out_valid), 0);
    chk("t6_rst_sum",   32'(bus.out_sum),   0);
    chk("t6_rst_count", 32'(bus.out_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_emit", 32'(bus.out_valid), 0);
    end
    send(4'd1, 1'b0);
    send(4'd2, 1'b1);
    wait_valid(10, n);
    chk("t6_valid", 32'(bus.out_valid), 1);
    chk("t6_sum",   32'(bus.out_sum),   3);
    chk("t6_count", 32'(bus.out_count), 2);
    take();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
